// File: rtl/cpoo_pkg.sv
// Shared types and default widths for the RAM arbiter and related blocks.
package cpoo_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder; returns the first set
// request at or above ptr, wrapping around.
module rr_picker #(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
            cand = sum[ID_W-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM txs/txe port between N_REQ requesters.
// Optional RAM_ARB_TIMEOUT_EN aborts a transaction after TIMEOUT cycles in WAIT.
module ram_arbiter
    import cpoo_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_txs,
    input  logic [N_REQ-1:0]           req_re,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wd,
    output logic [N_REQ-1:0]           req_txe,
    output logic [N_REQ-1:0]           req_err,
    output logic [DATA_W-1:0]          req_rd,
    output logic                       ram_txs,
    output logic                       ram_re,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wd,
    input  logic                       ram_txe,
    input  logic                       ram_err,
    input  logic [DATA_W-1:0]          ram_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   gid_d;
    logic              txs_d, re_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wd_d, rd_d;
    logic [N_REQ-1:0]  txe_d, err_d;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;
    logic [ID_W-1:0]   rr_after;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_q, tmo_d;
`endif

    rr_picker #(.N(N_REQ), .ID_W(ID_W)) u_picker (
        .req   (req_txs),
        .ptr   (rr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign rr_after = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = grant_id;
        txs_d   = ram_txs;
        re_d    = ram_re;
        we_d    = ram_we;
        addr_d  = ram_addr;
        wd_d    = ram_wd;
        rd_d    = req_rd;
        txe_d   = req_txe;
        err_d   = req_err;
`ifdef RAM_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gid_d   = pick_idx;
                    txs_d   = 1'b1;
                    re_d    = req_re[pick_idx];
                    we_d    = req_we[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wd_d    = req_wd[pick_idx*DATA_W +: DATA_W];
                    state_d = WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (ram_txe) begin
                    rd_d           = ram_out;
                    err_d[grant_id] = ram_err;
                    txe_d[grant_id] = 1'b1;
                    re_d           = 1'b0;
                    we_d           = 1'b0;
                    state_d        = RELEASE;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    rd_d            = '0;
                    err_d[grant_id] = 1'b1;
                    txe_d[grant_id] = 1'b1;
                    txs_d           = 1'b0;
                    re_d            = 1'b0;
                    we_d            = 1'b0;
                    state_d         = RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!req_txs[grant_id]) begin
                    txe_d   = '0;
                    err_d   = '0;
                    txs_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Address and data stay visible through DRAIN and clear on return to IDLE.
                if (!ram_txe) begin
                    rr_d    = rr_after;
                    addr_d  = '0;
                    wd_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            grant_id <= '0;
            ram_txs  <= 1'b0;
            ram_re   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_wd   <= '0;
            req_rd   <= '0;
            req_txe  <= '0;
            req_err  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_id <= gid_d;
            ram_txs  <= txs_d;
            ram_re   <= re_d;
            ram_we   <= we_d;
            ram_addr <= addr_d;
            ram_wd   <= wd_d;
            req_rd   <= rd_d;
            req_txe  <= txe_d;
            req_err  <= err_d;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// round-robin contention against a behavioural RAM and arbitration model.
module tb_ram_arbiter;

    localparam int N   = 2;
    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           req_txs, req_re, req_we;
    logic [N*AW-1:0]        req_addr;
    logic [N*DW-1:0]        req_wd;
    logic [N-1:0]           req_txe, req_err;
    logic [DW-1:0]          req_rd;
    logic                   ram_txs, ram_re, ram_we;
    logic [AW-1:0]          ram_addr;
    logic [DW-1:0]          ram_wd;
    logic                   ram_txe = 1'b0;
    logic                   ram_err = 1'b0;
    logic [DW-1:0]          ram_out = '0;
    logic [$clog2(N)-1:0]   grant_id;
    logic                   busy;

    ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_txs(req_txs), .req_re(req_re), .req_we(req_we),
        .req_addr(req_addr), .req_wd(req_wd),
        .req_txe(req_txe), .req_err(req_err), .req_rd(req_rd),
        .ram_txs(ram_txs), .ram_re(ram_re), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wd(ram_wd),
        .ram_txe(ram_txe), .ram_err(ram_err), .ram_out(ram_out),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: answers after ram_lat cycles unless hung; read data is a fixed function of address.
    int lat_cnt = 0;
    int ram_lat = 1;
    bit ram_hang = 1'b0;
    bit ram_err_cfg = 1'b0;

    function automatic logic [31:0] rd_fn(input logic [63:0] a);
        return (a == 64'h10) ? 32'hDEAD_BEEF : ((a[31:0] ^ {a[63:48], a[15:0]}) + 32'h1357_9BDF);
    endfunction

    always @(negedge clk) begin
        if (!ram_txs) begin
            ram_txe <= 1'b0;
            ram_err <= 1'b0;
            ram_out <= '0;
            lat_cnt <= 0;
        end else if (!ram_txe && !ram_hang) begin
            if (lat_cnt + 1 >= ram_lat) begin
                ram_txe <= 1'b1;
                ram_err <= ram_err_cfg;
                ram_out <= ram_re ? rd_fn(ram_addr) : '0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int ref_ptr  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic re, input logic we,
                           input logic [63:0] a, input logic [31:0] d);
        req_re[i]            = re;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wd[i*DW +: DW]   = d;
        req_txs[i]           = 1'b1;
    endtask

    // Waits for a completion, checks it against the expected winner, then releases that requester.
    task automatic serve(input int exp, input logic [31:0] exp_rd, input logic exp_err,
                         input logic exp_ram_txs, output int cyc);
        cyc = 0;
        while (req_txe == '0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("txe_onehot", req_txe, (N)'(1) << exp);
        check("grant_id", grant_id, exp);
        check("req_rd", req_rd, exp_rd);
        check("req_err", req_err, (N)'(exp_err) << exp);
        check("ram_txs_at_txe", ram_txs, exp_ram_txs);
        check("ram_re_cleared", {ram_re, ram_we}, 2'b00);
        req_txs[exp] = 1'b0;
        @(negedge clk);
        check("txe_dropped", {req_txe, req_err}, '0);
        check("ram_txs_dropped", ram_txs, 1'b0);
        ref_ptr = (exp + 1) % N;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_busy", busy, 1'b0);
        check("idle_ram", {ram_txs, ram_re, ram_we, ram_addr, ram_wd}, '0);
    endtask

    initial begin
        int cyc;
        logic [N-1:0]  mask;
        logic [N-1:0]  r_re, r_we;
        logic [63:0]   r_addr [N];
        logic [31:0]   r_wd [N];
        bit            r_err;
        int            w;

        rst = 1'b1;
        req_txs = '0; req_re = '0; req_we = '0; req_addr = '0; req_wd = '0;
        #12;
        check("reset_outputs", {req_txe, req_err, req_rd, ram_txs, ram_re, ram_we, grant_id, busy}, '0);
        check("reset_addr_wd", {ram_addr, ram_wd}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_req", {ram_txs, busy}, 2'b00);

        // Single read with a 3-cycle RAM.
        ram_lat = 3; ram_err_cfg = 1'b0;
        set_req(0, 1'b1, 1'b0, 64'h10, 32'h0);
        @(negedge clk);
        check("rd_ram_txs", {ram_txs, ram_re, ram_we, busy}, 4'b1101);
        check("rd_ram_addr", ram_addr, 64'h10);
        serve(0, 32'hDEAD_BEEF, 1'b0, 1'b1, cyc);
        wait_idle();

        // Write answered with an error.
        ram_lat = 2; ram_err_cfg = 1'b1;
        set_req(1, 1'b0, 1'b1, 64'h20, 32'h1234_5678);
        @(negedge clk);
        check("wr_ram_ctrl", {ram_txs, ram_re, ram_we, grant_id}, 4'b1011);
        check("wr_ram_addr", ram_addr, 64'h20);
        check("wr_ram_wd", ram_wd, 32'h1234_5678);
        serve(1, 32'h0, 1'b1, 1'b1, cyc);
        wait_idle();

        // Contention: both held and re-raised once each, service alternates.
        ram_lat = 1; ram_err_cfg = 1'b0;
        set_req(0, 1'b1, 1'b0, 64'h100, 32'h0);
        set_req(1, 1'b1, 1'b0, 64'h200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            w = rr_pick(req_txs, ref_ptr);
            check("contention_order", w, k % 2);
            serve(w, rd_fn(w == 0 ? 64'h100 : 64'h200), 1'b0, 1'b1, cyc);
            if (k < 2) req_txs[w] = 1'b1;
        end
        wait_idle();

        // Attribute change after grant is ignored.
        ram_lat = 6;
        set_req(0, 1'b1, 1'b0, 64'h10, 32'h0);
        @(negedge clk);
        req_addr[0 +: AW] = 64'h99; req_re[0] = 1'b0; req_we[0] = 1'b1;
        cyc = 0;
        while (req_txe == '0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("attr_ram_addr_held", ram_addr, 64'h10);
        req_txs[0] = 1'b0;
        @(negedge clk);
        check("attr_drain_addr", ram_addr, 64'h10);
        check("attr_rd", req_rd, 32'hDEAD_BEEF);
        ref_ptr = 1;
        wait_idle();

        // Reset while in WAIT; the pointer was 1, reset must bring it back to 0.
        ram_hang = 1'b1;
        set_req(0, 1'b1, 1'b0, 64'h40, 32'h0);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", {busy, ram_txs}, 2'b11);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {req_txe, req_err, ram_txs, ram_re, ram_we, grant_id, busy}, '0);
        check("mid_reset_addr", ram_addr, '0);
        req_txs = '0;
        ram_hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = 0;
        @(negedge clk);
        ram_lat = 2;
        set_req(0, 1'b1, 1'b0, 64'h50, 32'h0);
        set_req(1, 1'b1, 1'b0, 64'h60, 32'h0);
        serve(0, rd_fn(64'h50), 1'b0, 1'b1, cyc);
        serve(1, rd_fn(64'h60), 1'b0, 1'b1, cyc);
        wait_idle();

        // Randomized bursts: random subset raised together, served in round-robin order.
        for (int it = 0; it < 12; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            ram_lat = $urandom_range(1, 4);
            r_err = 1'($urandom_range(0, 1));
            ram_err_cfg = r_err;
            for (int i = 0; i < N; i++) begin
                r_re[i] = 1'($urandom_range(0, 1));
                r_we[i] = 1'($urandom_range(0, 1));
                r_addr[i] = {$urandom, $urandom};
                r_wd[i] = $urandom;
                if (mask[i]) set_req(i, r_re[i], r_we[i], r_addr[i], r_wd[i]);
            end
            while (mask != '0) begin
                w = rr_pick(mask, ref_ptr);
                cyc = 0;
                while (req_txe == '0 && cyc < 64) begin
                    @(negedge clk);
                    cyc++;
                end
                check("rand_ram_addr", ram_addr, r_addr[w]);
                check("rand_ram_wd", ram_wd, r_wd[w]);
                serve(w, r_re[w] ? rd_fn(r_addr[w]) : 32'h0, r_err, 1'b1, cyc);
                mask[w] = 1'b0;
            end
            wait_idle();
        end

`ifdef RAM_ARB_TIMEOUT_EN
        // RAM never answers: abort exactly TMO cycles after entering WAIT.
        ram_hang = 1'b1;
        set_req(0, 1'b1, 1'b0, 64'h70, 32'h0);
        @(negedge clk);
        serve(0, 32'h0, 1'b1, 1'b0, cyc);
        check("timeout_cycles", cyc, TMO);
        wait_idle();
        ram_hang = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
